// File: rtl/rgb_frame_fetch.sv
// rgb_frame_fetch: streams one frame of packed RGB pixels out of SRAM.
// Each group of three 16-bit words carries two 24-bit pixels. A group is
// fetched as three back-to-back reads and unpacked into a small pixel FIFO
// that feeds a valid/ready consumer.
module rgb_frame_fetch #(
    parameter logic [17:0] BASE_ADDR  = 18'd146944,
    parameter int unsigned NUM_PIXELS = 76800,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [15:0] SRAM_write_data,
    output logic        Pixel_valid,
    input  logic        Pixel_ready,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Busy,
    output logic        Frame_done
);

    localparam int unsigned NUM_WORDS = 3 * NUM_PIXELS / 2;
    localparam logic [17:0] LAST_ADDR = 18'(BASE_ADDR + NUM_WORDS - 1);
    localparam logic [16:0] LAST_PIX  = 17'(NUM_PIXELS - 1);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam int          SW        = CW + 1;
    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    state_t        state;
    logic [1:0]    grp_phase;   // word of the current group issued next: 0=w0, 1=w1, 2=w2
    logic [17:0]   addr_cnt;    // next SRAM address to issue
    logic [16:0]   pix_cnt;     // pixels handed to the consumer this frame

    // Read-return tracking: which group word arrives on SRAM_read_data.
    logic          s1_vld, s2_vld;
    logic [1:0]    s1_ph, s2_ph;
    logic [7:0]    r0, g0, b0, r1;

    pixel_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] in_flight;   // pixels of started groups not yet in the FIFO

    logic          room, start_grp, issue, push, pop;
    pixel_t        head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign SRAM_we_n       = 1'b1;
    assign SRAM_write_data = 16'd0;
    assign Pixel_valid     = (fifo_count != '0);
    assign head            = Pixel_valid ? fifo_mem[rd_ptr] : '0;
    assign Pixel_R         = head.r;
    assign Pixel_G         = head.g;
    assign Pixel_B         = head.b;

    // Issue / push / pop decisions for the current cycle.
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    always_comb begin
        room      = ({1'b0, fifo_count} + {1'b0, in_flight} + SW'(2)) <= SW'(FIFO_DEPTH);
        start_grp = (state == FETCH) && (grp_phase == 2'd0) && room;
        issue     = (state == FETCH) && ((grp_phase != 2'd0) || room);
        push      = s2_vld && (s2_ph == 2'd2);
        pop       = Pixel_valid && Pixel_ready;
    end

    // Frame sequencing: address generation, pixel counting, Busy and Frame_done.
    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            grp_phase    <= 2'd0;
            addr_cnt     <= '0;
            pix_cnt      <= '0;
            SRAM_address <= '0;
            Busy         <= 1'b0;
            Frame_done   <= 1'b0;
        end else begin
            Frame_done <= 1'b0;
            if (pop) pix_cnt <= pix_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state     <= FETCH;
                        Busy      <= 1'b1;
                        addr_cnt  <= BASE_ADDR;
                        grp_phase <= 2'd0;
                        pix_cnt   <= '0;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        SRAM_address <= addr_cnt;
                        // Hold the counter on the final word so it never wraps.
                        if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
                        if (grp_phase == 2'd2) begin
                            grp_phase <= 2'd0;
                            if (addr_cnt == LAST_ADDR) state <= DRAIN;
                        end else begin
                            grp_phase <= grp_phase + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (pix_cnt == LAST_PIX)) begin
                        state      <= IDLE;
                        Busy       <= 1'b0;
                        Frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track each issued word through the two-cycle SRAM latency and unpack it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_vld <= 1'b0;
            s1_ph  <= 2'd0;
            s2_vld <= 1'b0;
            s2_ph  <= 2'd0;
            r0     <= '0;
            g0     <= '0;
            b0     <= '0;
            r1     <= '0;
        end else begin
            s1_vld <= issue;
            s1_ph  <= grp_phase;
            s2_vld <= s1_vld;
            s2_ph  <= s1_ph;
            if (s2_vld) begin
                case (s2_ph)
                    2'd0:    {r0, g0} <= SRAM_read_data;
                    2'd1:    {b0, r1} <= SRAM_read_data;
                    default: ;  // w2 goes straight into the FIFO
                endcase
            end
        end
    end

    // FIFO pointers, occupancy and reservation for groups still in the SRAM pipe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_flight  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(2);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                2'b11:   fifo_count <= fifo_count + CW'(1);
                default: ;
            endcase
            case ({start_grp, push})
                2'b10:   in_flight <= in_flight + CW'(2);
                2'b01:   in_flight <= in_flight - CW'(2);
                default: ;
            endcase
        end
    end

    // Pixel storage: both pixels of a group land on the w2 capture edge, pixel 0 first.
    // NOTE: storage is not reset; fifo_count alone decides which entries are live.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr]          <= {r0, g0, b0};
            fifo_mem[ptr_inc(wr_ptr)] <= {r1, SRAM_read_data[15:8], SRAM_read_data[7:0]};
        end
    end

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Bench for rgb_frame_fetch: a short frame ending exactly at the top SRAM word,
// checked against a pixel model derived from the packing rule.
module tb_rgb_frame_fetch;

    localparam logic [17:0] BASE  = 18'd261844;
    localparam int          NP    = 200;
    localparam int          DEPTH = 8;
    localparam logic [17:0] LAST  = 18'd262143;
    localparam int          NW    = NP * 3 / 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = 16'd0;
    logic        SRAM_we_n;
    logic [15:0] SRAM_write_data;
    logic        Pixel_valid;
    logic        Pixel_ready = 1'b1;
    logic [7:0]  Pixel_R, Pixel_G, Pixel_B;
    logic        Busy;
    logic        Frame_done;

    int total = 0;
    int bad   = 0;

    rgb_frame_fetch #(
        .BASE_ADDR  (BASE),
        .NUM_PIXELS (NP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Start           (Start),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_write_data (SRAM_write_data),
        .Pixel_valid     (Pixel_valid),
        .Pixel_ready     (Pixel_ready),
        .Pixel_R         (Pixel_R),
        .Pixel_G         (Pixel_G),
        .Pixel_B         (Pixel_B),
        .Busy            (Busy),
        .Frame_done      (Frame_done)
    );

    initial forever #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM contents: first three words fixed, the rest a simple address hash.
    function automatic logic [15:0] mem_word(input logic [17:0] a);
        logic [17:0] off = a - BASE;
        case (off)
            18'd0:   return 16'h1122;
            18'd1:   return 16'h3344;
            18'd2:   return 16'h5566;
            default: return 16'(a * 18'd40503) ^ 16'h5A5A;
        endcase
    endfunction

    // Pixel i of the frame from the three-word packing rule.
    function automatic logic [23:0] model_pixel(input int i);
        logic [17:0] a  = 18'(BASE + 3 * (i / 2));
        logic [15:0] w0 = mem_word(a);
        logic [15:0] w1 = mem_word(a + 18'd1);
        logic [15:0] w2 = mem_word(a + 18'd2);
        return (i % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
    endfunction

    // SRAM: data for an address driven after edge n is sampled by the DUT at edge n+2.
    always @(posedge Clock) SRAM_read_data <= mem_word(SRAM_address);

    // Consumer: 0 = always ready, 1 = every other cycle, 2 = stalled.
    int   ready_mode = 0;
    logic tog = 1'b0;
    initial forever begin
        @(posedge Clock);
        #1;
        tog = ~tog;
        case (ready_mode)
            0:       Pixel_ready = 1'b1;
            1:       Pixel_ready = tog;
            default: Pixel_ready = 1'b0;
        endcase
    end

    // Scoreboard state, updated only by the compare process.
    int          xfer_idx    = 0;
    int          words       = 0;
    logic [17:0] prev_addr   = 18'd0;
    logic        pv          = 1'b0;
    logic        pr          = 1'b0;
    logic [23:0] prgb        = 24'd0;
    int          done_pulses = 0;
    int          snap_xfers  = 0;
    int          snap_words  = 0;
    logic        uf_check    = 1'b0;

    // Compare process: mid-cycle check of address order, FIFO bound, stall hold and pixel data.
    initial forever begin
        @(negedge Clock);
        if (Reset) begin
            xfer_idx  = 0;
            words     = 0;
            prev_addr = 18'd0;
            pv        = 1'b0;
        end else begin
            if (SRAM_address != prev_addr) begin
                check("addr_seq", SRAM_address, 18'(BASE + words));
                words++;
                prev_addr = SRAM_address;
            end
            check("fifo_bound", (2 * ((words + 2) / 3) - xfer_idx) <= DEPTH, 1'b1);
            if (pv && !pr) begin
                check("stall_valid", Pixel_valid, 1'b1);
                check("stall_hold", {Pixel_R, Pixel_G, Pixel_B}, prgb);
            end
            if (uf_check && Pixel_ready && xfer_idx > 0 && words < NW)
                check("underflow", Pixel_valid, 1'b1);
            if (Pixel_valid && Pixel_ready) begin
                check("extra_pixel", xfer_idx < NP, 1'b1);
                check("pixel", {Pixel_R, Pixel_G, Pixel_B}, model_pixel(xfer_idx));
                xfer_idx++;
            end
            if (Frame_done) begin
                done_pulses++;
                snap_xfers = xfer_idx;
                snap_words = words;
                xfer_idx   = 0;
                words      = 0;
            end
            pv   = Pixel_valid;
            pr   = Pixel_ready;
            prgb = {Pixel_R, Pixel_G, Pixel_B};
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Start a frame with the consumer ready and pin the first-pixel timing.
    task automatic start_frame_checked();
        pulse_start();                       // edge E0 samples Start
        tick();
        check("first_addr", SRAM_address, BASE);
        tick(); tick(); tick();
        check("valid_before_e5", Pixel_valid, 1'b0);
        tick();
        check("valid_at_e5", Pixel_valid, 1'b1);
        check("pix0", {Pixel_R, Pixel_G, Pixel_B}, 24'h112233);
        tick();
        check("pix1", {Pixel_R, Pixel_G, Pixel_B}, 24'h445566);
    endtask

    task automatic wait_done(input int budget);
        int d0   = done_pulses;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_pulses != d0) seen = 1'b1;
        end
        check("frame_done_seen", seen, 1'b1);
        tick();
        check("one_done_pulse", done_pulses - d0, 1);
        check("done_pulse_low", Frame_done, 1'b0);
        check("busy_low", Busy, 1'b0);
        check("xfers", snap_xfers, NP);
        check("words", snap_words, NW);
        check("last_addr_hold", SRAM_address, LAST);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, SRAM_address, 18'd0);
        check({tag, "_we_n"}, SRAM_we_n, 1'b1);
        check({tag, "_wdata"}, SRAM_write_data, 16'd0);
        check({tag, "_valid"}, Pixel_valid, 1'b0);
        check({tag, "_rgb"}, {Pixel_R, Pixel_G, Pixel_B}, 24'd0);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_done"}, Frame_done, 1'b0);
    endtask

    logic [17:0] a_hold;
    bit          found;
    int          occ;

    initial begin
        #12;
        check_reset_outputs("reset");
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        tick(); tick();

        // Frame 1: consumer always ready.
        ready_mode = 0;
        start_frame_checked();
        check("we_n_mid", SRAM_we_n, 1'b1);
        check("wdata_mid", SRAM_write_data, 16'd0);
        check("busy_mid", Busy, 1'b1);
        wait_done(2000);

        // Frame 2: 20-cycle stall, then a Start that must be ignored.
        start_frame_checked();
        repeat (30) tick();
        ready_mode = 2;
        repeat (12) tick();
        a_hold = SRAM_address;
        repeat (8) tick();
        check("stall_addr_hold", SRAM_address, a_hold);
        occ = 2 * ((words + 2) / 3) - xfer_idx;
        check("stall_fill", occ >= DEPTH - 1, 1'b1);
        check("stall_valid_main", Pixel_valid, 1'b1);
        ready_mode = 0;
        repeat (10) tick();
        pulse_start();
        check("start_ignored_busy", Busy, 1'b1);
        wait_done(2000);

        // Frame 3: consumer ready every other cycle.
        ready_mode = 1;
        uf_check   = 1'b1;
        pulse_start();
        wait_done(3000);
        uf_check   = 1'b0;

        // Frame 4: reset inside a group, then a clean restart.
        ready_mode = 0;
        tick();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (SRAM_address == BASE + 18'd4) found = 1'b1;
        end
        check("reach_mid_group", found, 1'b1);
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        tick(); tick();
        start_frame_checked();
        wait_done(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_frame_fetch.md
RGB_FRAME_FETCH -- requirements
Module: rgb_frame_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 18'd146944, SHALL be the SRAM word address of the first packed RGB word.
REQ-002 Parameter NUM_PIXELS, default 76800 (320x240), SHALL be the pixel count per frame; it is even.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL be the pixel FIFO depth in pixels.
REQ-004 Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 Start  in  1  SHALL be a one-cycle frame-start request, honoured only in IDLE.
REQ-007 SRAM_address  out  18  SHALL be the registered SRAM read address.
REQ-008 SRAM_read_data  in  16  SHALL be the SRAM data, valid 2 cycles after its address is driven.
REQ-009 SRAM_we_n  out  1  SHALL be held at 1 (read only).
REQ-010 SRAM_write_data  out  16  SHALL be held at 16'd0.
REQ-011 Pixel_valid  out  1  SHALL indicate that Pixel_R/G/B hold the FIFO head pixel.
REQ-012 Pixel_ready  in  1  SHALL be the consumer accept signal; a pixel transfers when Pixel_valid and Pixel_ready are both 1.
REQ-013 Pixel_R, Pixel_G, Pixel_B  out  8 each  SHALL be the head pixel colour components.
REQ-014 Busy  out  1  SHALL be 1 from Start acceptance until the Frame_done pulse.
REQ-015 Frame_done  out  1  SHALL be a one-cycle pulse after the last pixel of the frame transfers.

Function
REQ-016 Pixels SHALL be packed in 3-word groups: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}, with the high byte first; group k occupies BASE_ADDR+3k..3k+2.
REQ-017 The FSM SHALL have states IDLE, FETCH and DRAIN; Reset enters IDLE.
REQ-018 IDLE->FETCH SHALL occur on Start=1; the first address (BASE_ADDR) is driven in the following cycle.
REQ-019 In FETCH, a group SHALL issue 3 consecutive addresses on 3 consecutive cycles; no gap is allowed within a group.
REQ-020 A new group SHALL begin only when FIFO count + in-flight pixels + 2 <= FIFO_DEPTH; otherwise SRAM_address holds its value.
REQ-021 Returning words SHALL be captured at issue+2; on the w2 capture edge, both pixels SHALL be written into the FIFO (pixel 0 first).
REQ-022 The FIFO SHALL support a 2-pixel push and a 1-pixel pop on the same edge; count changes by +1 in that case.
REQ-023 The FIFO SHALL never overflow or underflow; Pixel_valid SHALL be 1 whenever count > 0.
REQ-024 Pixel_R/G/B SHALL hold stable while Pixel_valid=1 and Pixel_ready=0.
REQ-025 After the last group (3*NUM_PIXELS/2 = 115200 words, last address 262143) issues, FETCH->DRAIN SHALL occur; no further addresses are issued and SRAM_address holds 262143.
REQ-026 DRAIN->IDLE SHALL occur on the transfer of pixel NUM_PIXELS-1; Frame_done pulses and Busy falls in the next cycle.
REQ-027 Start SHALL be ignored while Busy=1.
REQ-028 The address counter SHALL be 18 bits; the pixel counter SHALL be 17 bits; neither wraps within a frame.
REQ-029 Throughput with Pixel_ready held at 1 SHALL be 2 pixels per 3 cycles in the steady state.

Reset
REQ-030 On Reset, the block SHALL return to IDLE and set SRAM_address=0, SRAM_we_n=1, SRAM_write_data=0, Pixel_valid=0, Pixel_R/G/B=0, Busy=0 and Frame_done=0.
REQ-031 On Reset, the FIFO count, in-flight count and address and pixel counters SHALL clear.
REQ-032 Reset mid-frame SHALL discard all in-flight data; read data returning after Reset is ignored.

Verification
REQ-033 Start, Pixel_ready=1, SRAM model with 2-cycle latency, words 16'h1122, 16'h3344, 16'h5566 -> first pixel R=11 G=22 B=33, second R=44 G=55 B=66; first Pixel_valid at the 5th edge after Start.
REQ-034 Full frame with Pixel_ready=1 -> exactly 76800 transfers, last read address 262143, one Frame_done pulse, Busy low afterwards.
REQ-035 Pixel_ready=0 for 20 cycles mid-frame -> count saturates at 8, address holds, no pixel lost or duplicated, and data is stable while stalled.
REQ-036 Pixel_ready toggling 1 cycle on / 1 cycle off (VGA rate) -> no underflow while fetching, and pixel order matches the SRAM contents.
REQ-037 Start asserted again mid-frame -> ignored, no address perturbation.
REQ-038 Reset asserted mid-group, then Start -> outputs return to reset values immediately, and the new frame restarts at BASE_ADDR with a correct first pixel.
